// File: rtl/reg_bank_mp.sv
// Two-read / two-write register file with write-through bypass, hardwired zero
// register, per-register busy scoreboard and a one-entry-per-cycle clear engine.

module reg_bank_mp_rd_lane #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                                 idle,
   input  logic [ADDR_W-1:0]                    sr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   rf,
   input  logic [(2**ADDR_W)-1:0]               busy_vec,
   input  logic [1:0]                           wr_en,
   input  logic [1:0][ADDR_W-1:0]               wr_addr,
   input  logic [1:0][DATA_W-1:0]               wr_data,
   output logic [DATA_W-1:0]                    rdata,
   output logic                                 busy
);

   always_comb begin
      rdata = rf[sr];
      // Port 1 is checked first so it wins the forward, matching write priority.
      if (BYPASS != 0 && idle) begin
         if (wr_en[1] && wr_addr[1] == sr)
            rdata = wr_data[1];
         else if (wr_en[0] && wr_addr[0] == sr)
            rdata = wr_data[0];
      end
      if (ZERO_REG != 0 && sr == '0)
         rdata = '0;
      if (!idle)
         rdata = '0;
   end

   assign busy = busy_vec[sr];

endmodule

module reg_bank_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   output logic                     ready,
   input  logic [ADDR_W-1:0]        sr1,
   input  logic [ADDR_W-1:0]        sr2,
   output logic signed [DATA_W-1:0] rData1,
   output logic signed [DATA_W-1:0] rData2,
   output logic                     busy1,
   output logic                     busy2,
   input  logic                     write0,
   input  logic [ADDR_W-1:0]        dr0,
   input  logic [DATA_W-1:0]        wrData0,
   input  logic                     write1,
   input  logic [ADDR_W-1:0]        dr1,
   input  logic [DATA_W-1:0]        wrData1,
   input  logic                     busy_set,
   input  logic [ADDR_W-1:0]        busy_dr
);

   localparam int DEPTH    = 2**ADDR_W;
   localparam int RD_PORTS = 2;
   localparam int WR_PORTS = 2;

   typedef enum logic {CLEAR, IDLE} state_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   state_t                         state_q, state_d;
   logic [ADDR_W-1:0]              cnt_q, cnt_d;
   logic [DEPTH-1:0]               busy_q, busy_d;
   logic                           ready_q, ready_d;
   logic [DEPTH-1:0][DATA_W-1:0]   regfile_q, regfile_d;

   wr_req_t [WR_PORTS-1:0]         wr_req;
   logic [WR_PORTS-1:0]            wr_en;
   logic [WR_PORTS-1:0][ADDR_W-1:0] wr_addr;
   logic [WR_PORTS-1:0][DATA_W-1:0] wr_data;

   logic [RD_PORTS-1:0][ADDR_W-1:0] rd_addr;
   logic [RD_PORTS-1:0][DATA_W-1:0] rd_data;
   logic [RD_PORTS-1:0]             rd_busy;
   logic                            idle;

   assign wr_req[0] = '{en: write0, addr: dr0, data: wrData0};
   assign wr_req[1] = '{en: write1, addr: dr1, data: wrData1};
   assign idle      = (state_q == IDLE);

   for (genvar p = 0; p < WR_PORTS; p++) begin : g_wr
      assign wr_en[p]   = wr_req[p].en;
      assign wr_addr[p] = wr_req[p].addr;
      assign wr_data[p] = wr_req[p].data;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      regfile_d = regfile_q;
      case (state_q)
         CLEAR: begin
            regfile_d[cnt_q] = '0;
            cnt_d            = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1))
               state_d = IDLE;
         end
         IDLE: begin
            // Ascending port order lets port 1 overwrite port 0 on an address clash.
            for (int p = 0; p < WR_PORTS; p++) begin
               if (wr_en[p]) begin
                  if (!(ZERO_REG != 0 && wr_addr[p] == '0))
                     regfile_d[wr_addr[p]] = wr_data[p];
                  busy_d[wr_addr[p]] = 1'b0;
               end
            end
            if (busy_set && !(ZERO_REG != 0 && busy_dr == '0))
               busy_d[busy_dr] = 1'b1;
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
               busy_d  = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   // Array contents need no reset: the clear engine rewrites every entry.
   always_ff @(posedge clk) begin
      if (!reset)
         regfile_q <= regfile_d;
   end

   assign rd_addr[0] = sr1;
   assign rd_addr[1] = sr2;

   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      reg_bank_mp_rd_lane #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_lane (
         .idle     (idle),
         .sr       (rd_addr[k]),
         .rf       (regfile_q),
         .busy_vec (busy_q),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rdata    (rd_data[k]),
         .busy     (rd_busy[k])
      );
   end

   assign ready  = ready_q;
   assign rData1 = rd_data[0];
   assign rData2 = rd_data[1];
   assign busy1  = rd_busy[0];
   assign busy2  = rd_busy[1];

endmodule

// File: tb/tb_reg_bank_mp.sv
// Random + directed bench for reg_bank_mp; a reference model predicts each
// cycle's outputs into a queue that an independent monitor drains and checks.

module tb_reg_bank_mp;

   logic               clk = 1'b0;
   logic               reset, clr, ready;
   logic [3:0]         sr1, sr2, dr0, dr1, busy_dr;
   logic signed [31:0] rData1, rData2;
   logic               busy1, busy2, write0, write1, busy_set;
   logic [31:0]        wrData0, wrData1;

   reg_bank_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .clr(clr), .ready(ready),
      .sr1(sr1), .sr2(sr2), .rData1(rData1), .rData2(rData2),
      .busy1(busy1), .busy2(busy2),
      .write0(write0), .dr0(dr0), .wrData0(wrData0),
      .write1(write1), .dr1(dr1), .wrData1(wrData1),
      .busy_set(busy_set), .busy_dr(busy_dr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rdy;
      logic [31:0] r1, r2;
      bit          b1, b2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: architectural view only (contents, busy set, clear countdown).
   logic [31:0] mem [16];
   bit   [15:0] mbusy;
   bit          in_clear;
   int          clear_left;
   bit          model_init = 0;

   function automatic logic [31:0] m_rd(logic [3:0] a);
      if (in_clear || a == 4'd0) return 32'd0;
      if (write1 && dr1 == a) return wrData1;
      if (write0 && dr0 == a) return wrData0;
      return mem[a];
   endfunction

   task automatic model_edge();
      if (reset) begin
         in_clear   = 1;
         clear_left = 16;
         mbusy      = '0;
         model_init = 1;
      end else if (in_clear) begin
         clear_left--;
         if (clear_left == 0) begin
            in_clear = 0;
            for (int i = 0; i < 16; i++) mem[i] = 32'd0;
         end
      end else begin
         if (write0 && dr0 != 4'd0) mem[dr0] = wrData0;
         if (write1 && dr1 != 4'd0) mem[dr1] = wrData1;
         if (write0) mbusy[dr0] = 1'b0;
         if (write1) mbusy[dr1] = 1'b0;
         if (busy_set && busy_dr != 4'd0) mbusy[busy_dr] = 1'b1;
         if (clr) begin
            in_clear   = 1;
            clear_left = 16;
            mbusy      = '0;
         end
      end
   endtask

   task automatic step();
      exp_t e;
      if (model_init) begin
         e.rdy = !in_clear;
         e.r1  = m_rd(sr1);
         e.r2  = m_rd(sr2);
         e.b1  = mbusy[sr1];
         e.b2  = mbusy[sr2];
         exp_q.push_back(e);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_in();
      reset = 0; clr = 0; write0 = 0; write1 = 0; busy_set = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
      end
   endtask

   // Monitor: outputs are combinational and present every cycle; check mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready",  {31'd0, ready}, {31'd0, e.rdy});
            chk("rData1", rData1, e.r1);
            chk("rData2", rData2, e.r2);
            chk("busy1",  {31'd0, busy1}, {31'd0, e.b1});
            chk("busy2",  {31'd0, busy2}, {31'd0, e.b2});
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mbusy = '0; in_clear = 1; clear_left = 16;
      idle_in();
      reset = 1; sr1 = 4'd5; sr2 = 4'd5; dr0 = 0; dr1 = 0; busy_dr = 0;
      wrData0 = 0; wrData1 = 0;
      step();
      reset = 0;
      for (int i = 0; i < 18; i++) step();

      // bypass then persistence
      write0 = 1; dr0 = 4'd3; wrData0 = 32'h12345678; sr1 = 4'd3; step();
      write0 = 0; step();

      // dual write collision
      write0 = 1; dr0 = 4'd7; wrData0 = 32'h0000AAAA;
      write1 = 1; dr1 = 4'd7; wrData1 = 32'h00005555; sr2 = 4'd7; step();
      idle_in(); step();

      // zero register
      write1 = 1; dr1 = 4'd0; wrData1 = 32'hFFFFFFFF; sr1 = 4'd0; step();
      write1 = 0; step();
      busy_set = 1; busy_dr = 4'd0; step();
      busy_set = 0; step();

      // scoreboard set/clear priority
      sr1 = 4'd9; busy_set = 1; busy_dr = 4'd9; step();
      busy_set = 0; step();
      busy_set = 1; write0 = 1; dr0 = 4'd9; wrData0 = 32'h1; step();
      idle_in(); step();
      write0 = 1; dr0 = 4'd9; wrData0 = 32'h2; step();
      idle_in(); step();

      // clear with ignored write and reset mid-clear
      write0 = 1; dr0 = 4'd4; wrData0 = 32'h77; sr1 = 4'd4; step();
      write0 = 0; busy_set = 1; busy_dr = 4'd6; step();
      busy_set = 0; clr = 1; step();
      clr = 0; write0 = 1; dr0 = 4'd4; wrData0 = 32'h99; step();
      write0 = 0;
      for (int i = 0; i < 7; i++) step();
      reset = 1; step();
      reset = 0;
      for (int i = 0; i < 17; i++) step();
      for (int i = 0; i < 16; i++) begin
         sr1 = 4'(i); sr2 = 4'(15 - i); step();
      end

      // randomized traffic with address collisions biased in
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom_range(0, 299) == 0);
         clr      = ($urandom_range(0, 79) == 0);
         write0   = $urandom_range(0, 1);
         write1   = $urandom_range(0, 1);
         busy_set = ($urandom_range(0, 2) == 0);
         dr0      = 4'($urandom_range(0, 15));
         dr1      = ($urandom_range(0, 3) == 0) ? dr0 : 4'($urandom_range(0, 15));
         busy_dr  = ($urandom_range(0, 2) == 0) ? dr0 : 4'($urandom_range(0, 15));
         wrData0  = $urandom;
         wrData1  = $urandom;
         sr1      = ($urandom_range(0, 2) == 0) ? dr1 : 4'($urandom_range(0, 15));
         sr2      = ($urandom_range(0, 2) == 0) ? dr0 : 4'($urandom_range(0, 15));
         step();
      end

      idle_in();
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
